inst_mem_loader: RTL

//  Write-side counterpart of the instruction memory: receives a program image as a byte stream
//  (valid/ready) and writes consecutive 16-bit instruction words via a synchronous write port.

---
 rtl/inst_mem_loader.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/inst_mem_loader.sv
// Byte-stream program loader: LEN_HI, LEN_LO, then N {hi,lo} words written to instruction memory.
// Optional trailing XOR checksum byte when INST_LOADER_CHECKSUM_EN is defined.
module inst_mem_loader #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_written
);

  typedef enum logic [2:0] {
    StIdle, StLenHi, StLenLo, StDataHi, StDataLo, StLast, StChk
  } state_e;

  // Words that fit between BASE_ADDR and the top of memory.
  localparam logic [32:0] Capacity = (33'd1 << ADDR_WIDTH) - 33'(BASE_ADDR);

  state_e                state_q, state_d;
  logic [7:0]            len_hi_q, len_hi_d;
  logic [15:0]           len_q, len_d;
  logic [7:0]            hi_q, hi_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]           mem_wdata_q, mem_wdata_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [ADDR_WIDTH:0]   ww_q, ww_d;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif
  logic                  xfer;
  logic [15:0]           len_rx;

  assign rx_ready = (state_q == StLenHi) || (state_q == StLenLo) || (state_q == StDataHi) ||
                    (state_q == StDataLo) || (state_q == StChk);
  assign xfer     = rx_valid && rx_ready;
  assign len_rx   = {len_hi_q, rx_data};

  always_comb begin
    state_d     = state_q;
    len_hi_d    = len_hi_q;
    len_d       = len_q;
    hi_d        = hi_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    error_d     = error_q;
    ww_d        = ww_q;
`ifdef INST_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
    if (xfer && state_q != StChk) csum_d = csum_q ^ rx_data;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          ww_d    = '0;
`ifdef INST_LOADER_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
          state_d = StLenHi;
        end
      end
      StLenHi: begin
        if (xfer) begin
          len_hi_d = rx_data;
          state_d  = StLenLo;
        end
      end
      StLenLo: begin
        if (xfer) begin
          len_d = len_rx;
          if (33'(len_rx) > Capacity) begin
            error_d = 1'b1;
            state_d = StIdle;
          end else if (len_rx == 16'h0000) begin
`ifdef INST_LOADER_CHECKSUM_EN
            state_d = StChk;
`else
            done_d  = 1'b1;
            state_d = StIdle;
`endif
          end else begin
            state_d = StDataHi;
          end
        end
      end
      StDataHi: begin
        if (xfer) begin
          hi_d    = rx_data;
          state_d = StDataLo;
        end
      end
      StDataLo: begin
        if (xfer) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = ADDR_WIDTH'(BASE_ADDR) + ww_q[ADDR_WIDTH-1:0];
          mem_wdata_d = {hi_q, rx_data};
          ww_d        = ww_q + (ADDR_WIDTH + 1)'(1);
          state_d     = (32'(ww_q) + 32'd1 == 32'(len_q)) ? StLast : StDataHi;
        end
      end
      StLast: begin
        // Strobe cycle of the final word; nothing is accepted here.
`ifdef INST_LOADER_CHECKSUM_EN
        state_d = StChk;
`else
        done_d  = 1'b1;
        state_d = StIdle;
`endif
      end
      StChk: begin
`ifdef INST_LOADER_CHECKSUM_EN
        if (xfer) begin
          if (rx_data == csum_q) done_d = 1'b1;
          else                   error_d = 1'b1;
          state_d = StIdle;
        end
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      len_hi_q    <= 8'h00;
      len_q       <= 16'h0000;
      hi_q        <= 8'h00;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 16'h0000;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      ww_q        <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      len_hi_q    <= len_hi_d;
      len_q       <= len_d;
      hi_q        <= hi_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      error_q     <= error_d;
      ww_q        <= ww_d;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign busy          = (state_q != StIdle);
  assign done          = done_q;
  assign error         = error_q;
  assign words_written = ww_q;

endmodule
